move_selector: RTL and testbench



---
 rtl/gobang_pkg.sv | 60 ++++++
 rtl/run_counter.sv | 59 +++++
 rtl/move_selector.sv | 230 +++++++++++++++++++++++
 tb/tb_move_selector.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gobang_pkg.sv
// Shared definitions for the gobang AI move-selection path.
//   chess_board : 225 cells x 2 bits, cell index = y*BOARD_N + x,
//                 2'b00 empty, 2'b01 black, 2'b10 white
//   state_t     : move_selector FSM states
//   w_own/w_opp : run-length score tables
//   cell_at     : bounds-checked cell read (out-of-range reads as 2'b11)
package gobang_pkg;

  localparam int BOARD_N  = 15;
  localparam int MAX_CAND = 10;
  localparam int CELLS    = BOARD_N * BOARD_N;

  typedef logic [2*CELLS-1:0] chess_board;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FORCE,
    ST_SCORE,
    ST_SCAN,
    ST_DONE
  } state_t;

  // W_OWN = {0,1,4,16,64}
  function automatic logic [9:0] w_own(input logic [2:0] run);
    case (run)
      3'd1:    return 10'd1;
      3'd2:    return 10'd4;
      3'd3:    return 10'd16;
      3'd4:    return 10'd64;
      default: return 10'd0;
    endcase
  endfunction

  // W_OPP = {0,1,3,12,48}
  function automatic logic [9:0] w_opp(input logic [2:0] run);
    case (run)
      3'd1:    return 10'd1;
      3'd2:    return 10'd3;
      3'd3:    return 10'd12;
      3'd4:    return 10'd48;
      default: return 10'd0;
    endcase
  endfunction

  function automatic logic [1:0] cell_at(input chess_board b,
                                         input logic [3:0] x,
                                         input logic [3:0] y);
    logic [8:0] idx;
    logic [8:0] lsb;
    idx = 9'(y) * 9'(BOARD_N) + 9'(x);
    lsb = idx << 1;
    if (idx < 9'(CELLS)) return b[lsb +: 2];
    return 2'b11;
  endfunction

endpackage

// File: rtl/run_counter.sv
// Combinational run-length counter.
//   board  : current board
//   x, y   : probe cell (must be on the board)
//   dir    : 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal
//   colour : stone code to count
//   run    : stones of `colour` contiguous on both sides of (x,y), capped at 4
module run_counter
  import gobang_pkg::*;
(
  input  chess_board  board,
  input  logic [3:0]  x,
  input  logic [3:0]  y,
  input  logic [1:0]  dir,
  input  logic [1:0]  colour,
  output logic [2:0]  run
);

  int         dx;
  int         dy;
  int         px;
  int         py;
  logic       alive;
  logic [3:0] cnt;

  always_comb begin
    dx    = 0;
    dy    = 0;
    px    = 0;
    py    = 0;
    alive = 1'b0;
    cnt   = '0;
    case (dir)
      2'd0: dx = 1;
      2'd1: dy = 1;
      2'd2: begin dx = 1; dy = 1;  end
      default: begin dx = 1; dy = -1; end
    endcase
    // Walk up to 4 cells each way; a side stops at the first miss or edge.
    for (int unsigned side = 0; side < 2; side++) begin
      alive = 1'b1;
      for (int unsigned step = 1; step <= 4; step++) begin
        if (side == 0) begin
          px = int'(x) + int'(step) * dx;
          py = int'(y) + int'(step) * dy;
        end else begin
          px = int'(x) - int'(step) * dx;
          py = int'(y) - int'(step) * dy;
        end
        if (alive && px >= 0 && px < BOARD_N && py >= 0 && py < BOARD_N &&
            cell_at(board, 4'(px), 4'(py)) == colour)
          cnt = cnt + 4'd1;
        else
          alive = 1'b0;
      end
    end
    run = (cnt > 4'd4) ? 3'd4 : cnt[2:0];
  end

endmodule

// File: rtl/move_selector.sv
// Move selector: scores the threat finder's candidate list and returns one move.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_start          : one-cycle pulse, candidate list valid (ignored unless idle)
//   i_turn           : side to move (0 black, 1 white)
//   i_board          : board, must stay stable until o_finish
//   i_posX, i_posY   : candidate coordinates, slot k at [5k+4:5k]
//   i_size           : number of valid slots (clamped to 10)
//   i_win            : nonzero forces slot 0
//   o_x, o_y, o_none : result, held until the next completion
//   o_finish         : one-cycle pulse, result valid
// Build option: MOVE_SEL_FALLBACK_EN enables the raster scan for the first
// empty cell when no candidate is usable; otherwise that case reports o_none.
module move_selector
  import gobang_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_turn,
  input  chess_board            i_board,
  input  logic [5*MAX_CAND-1:0] i_posX,
  input  logic [5*MAX_CAND-1:0] i_posY,
  input  logic [4:0]            i_size,
  input  logic [1:0]            i_win,
  output logic [3:0]            o_x,
  output logic [3:0]            o_y,
  output logic                  o_none,
  output logic                  o_finish
);

  state_t                state;
  logic                  turn;
  logic [5*MAX_CAND-1:0] pos_x;
  logic [5*MAX_CAND-1:0] pos_y;
  logic [3:0]            size;
  logic [3:0]            k;
  logic [1:0]            d;
  logic [9:0]            acc;
  logic [9:0]            best_score;
  logic [3:0]            best_x;
  logic [3:0]            best_y;
  logic                  has_best;
  logic                  tail;
`ifdef MOVE_SEL_FALLBACK_EN
  logic [3:0]            scan_x;
  logic [3:0]            scan_y;
`endif

  logic [5:0] slot_lsb;
  logic [4:0] cand_x;
  logic [4:0] cand_y;
  logic       cand_valid;
  logic [1:0] own_col;
  logic [1:0] opp_col;
  logic [2:0] run_own;
  logic [2:0] run_opp;
  logic [9:0] score_sum;
  logic       beats_best;
  logic       last_slot;

  always_comb begin
    slot_lsb   = 6'({2'b00, k} * 6'd5);
    cand_x     = pos_x[slot_lsb +: 5];
    cand_y     = pos_y[slot_lsb +: 5];
    cand_valid = (cand_x < 5'(BOARD_N)) && (cand_y < 5'(BOARD_N)) &&
                 (cell_at(i_board, cand_x[3:0], cand_y[3:0]) == CELL_EMPTY);
    own_col    = turn ? CELL_WHITE : CELL_BLACK;
    opp_col    = turn ? CELL_BLACK : CELL_WHITE;
    score_sum  = acc + w_own(run_own) + w_opp(run_opp);
    // Strictly greater: ties keep the lower slot index.
    beats_best = cand_valid && (!has_best || score_sum > best_score);
    last_slot  = (k == size - 4'd1);
  end

  run_counter u_run_own (
    .board  (i_board),
    .x      (cand_x[3:0]),
    .y      (cand_y[3:0]),
    .dir    (d),
    .colour (own_col),
    .run    (run_own)
  );

  run_counter u_run_opp (
    .board  (i_board),
    .x      (cand_x[3:0]),
    .y      (cand_y[3:0]),
    .dir    (d),
    .colour (opp_col),
    .run    (run_opp)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      turn       <= 1'b0;
      pos_x      <= '0;
      pos_y      <= '0;
      size       <= '0;
      k          <= '0;
      d          <= '0;
      acc        <= '0;
      best_score <= '0;
      best_x     <= '0;
      best_y     <= '0;
      has_best   <= 1'b0;
      tail       <= 1'b0;
`ifdef MOVE_SEL_FALLBACK_EN
      scan_x     <= '0;
      scan_y     <= '0;
`endif
      o_x        <= '0;
      o_y        <= '0;
      o_none     <= 1'b0;
      o_finish   <= 1'b0;
    end else begin
      o_finish <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (i_start) begin
            turn       <= i_turn;
            pos_x      <= i_posX;
            pos_y      <= i_posY;
            size       <= (i_size > 5'(MAX_CAND)) ? 4'(MAX_CAND) : i_size[3:0];
            k          <= '0;
            d          <= '0;
            acc        <= '0;
            best_score <= '0;
            best_x     <= '0;
            best_y     <= '0;
            has_best   <= 1'b0;
            tail       <= 1'b0;
            if (i_win != 2'b00 && i_size != 5'd0) begin
              state <= ST_FORCE;
            end else if (i_size != 5'd0) begin
              state <= ST_SCORE;
            end else begin
`ifdef MOVE_SEL_FALLBACK_EN
              scan_x <= '0;
              scan_y <= '0;
              state  <= ST_SCAN;
`else
              // Empty list: pass straight through the final SCORE cycle.
              tail  <= 1'b1;
              state <= ST_SCORE;
`endif
            end
          end
        end

        ST_FORCE: begin
          o_x      <= pos_x[3:0];
          o_y      <= pos_y[3:0];
          o_none   <= 1'b0;
          o_finish <= 1'b1;
          state    <= ST_DONE;
        end

        ST_SCORE: begin
          if (tail) begin
            // The winner is committed one cycle after the last candidate.
            o_x      <= has_best ? best_x : 4'd0;
            o_y      <= has_best ? best_y : 4'd0;
            o_none   <= !has_best;
            o_finish <= 1'b1;
            state    <= ST_DONE;
          end else begin
            d <= d + 2'd1;
            if (d != 2'd3) begin
              acc <= score_sum;
            end else begin
              acc <= '0;
              if (beats_best) begin
                best_score <= score_sum;
                best_x     <= cand_x[3:0];
                best_y     <= cand_y[3:0];
                has_best   <= 1'b1;
              end
              if (!last_slot) begin
                k <= k + 4'd1;
              end else begin
`ifdef MOVE_SEL_FALLBACK_EN
                if (!has_best && !cand_valid) begin
                  scan_x <= '0;
                  scan_y <= '0;
                  state  <= ST_SCAN;
                end else begin
                  tail <= 1'b1;
                end
`else
                tail <= 1'b1;
`endif
              end
            end
          end
        end

        ST_SCAN: begin
`ifdef MOVE_SEL_FALLBACK_EN
          if (cell_at(i_board, scan_x, scan_y) == CELL_EMPTY) begin
            o_x      <= scan_x;
            o_y      <= scan_y;
            o_none   <= 1'b0;
            o_finish <= 1'b1;
            state    <= ST_DONE;
          end else if (scan_x == 4'(BOARD_N - 1) && scan_y == 4'(BOARD_N - 1)) begin
            o_x      <= '0;
            o_y      <= '0;
            o_none   <= 1'b1;
            o_finish <= 1'b1;
            state    <= ST_DONE;
          end else if (scan_x == 4'(BOARD_N - 1)) begin
            scan_x <= '0;
            scan_y <= scan_y + 4'd1;
          end else begin
            scan_x <= scan_x + 4'd1;
          end
`else
          state <= ST_IDLE;
`endif
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_selector.sv
module tb_move_selector;
  import gobang_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_turn;
  chess_board  i_board;
  logic [49:0] i_posX;
  logic [49:0] i_posY;
  logic [4:0]  i_size;
  logic [1:0]  i_win;
  logic [3:0]  o_x;
  logic [3:0]  o_y;
  logic        o_none;
  logic        o_finish;

  always #5 i_clk = ~i_clk;

  move_selector dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (i_start),
    .i_turn   (i_turn),
    .i_board  (i_board),
    .i_posX   (i_posX),
    .i_posY   (i_posY),
    .i_size   (i_size),
    .i_win    (i_win),
    .o_x      (o_x),
    .o_y      (o_y),
    .o_none   (o_none),
    .o_finish (o_finish)
  );

  int checks = 0;
  int errors = 0;

  // Reference board bx[x][y]: 0 empty, 1 black, 2 white.
  int bx [15][15];
  int sx [10];
  int sy [10];
  int wown [5] = '{0, 1, 4, 16, 64};
  int wopp [5] = '{0, 1, 3, 12, 48};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int run_len(int x, int y, int dx, int dy, int col);
    int n = 0;
    for (int sgn = -1; sgn <= 1; sgn += 2) begin
      int px = x + sgn * dx;
      int py = y + sgn * dy;
      while (px >= 0 && px < 15 && py >= 0 && py < 15 && bx[px][py] == col) begin
        n++;
        px += sgn * dx;
        py += sgn * dy;
      end
    end
    return (n > 4) ? 4 : n;
  endfunction

  task automatic model(input int turn, input int win, input int size_raw,
                       output int ex, output int ey, output int en, output int lat);
    int dxs [4] = '{1, 0, 1, 1};
    int dys [4] = '{0, 1, 1, -1};
    int size, best, bs, s, own, opp;
    size = (size_raw > 10) ? 10 : size_raw;
    ex = 0; ey = 0; en = 0; lat = 0;
    if (win != 0 && size > 0) begin
      ex = sx[0] % 16; ey = sy[0] % 16; lat = 2;
      return;
    end
    own = turn ? 2 : 1;
    opp = turn ? 1 : 2;
    best = -1; bs = 0;
    for (int k = 0; k < size; k++) begin
      if (sx[k] < 15 && sy[k] < 15 && bx[sx[k]][sy[k]] == 0) begin
        s = 0;
        for (int dd = 0; dd < 4; dd++)
          s += wown[run_len(sx[k], sy[k], dxs[dd], dys[dd], own)] +
               wopp[run_len(sx[k], sy[k], dxs[dd], dys[dd], opp)];
        if (best < 0 || s > bs) begin best = k; bs = s; end
      end
    end
    if (best >= 0) begin
      ex = sx[best]; ey = sy[best]; lat = 4 * size + 2;
      return;
    end
`ifdef MOVE_SEL_FALLBACK_EN
    for (int i = 0; i < 225; i++) begin
      if (bx[i % 15][i / 15] == 0) begin
        ex = i % 15; ey = i / 15; lat = 4 * size + i + 2;
        return;
      end
    end
    en = 1; lat = 4 * size + 226;
`else
    en = 1; lat = 4 * size + 2;
`endif
  endtask

  task automatic clear_all();
    for (int x = 0; x < 15; x++)
      for (int y = 0; y < 15; y++) bx[x][y] = 0;
    for (int k = 0; k < 10; k++) begin sx[k] = 0; sy[k] = 0; end
  endtask

  task automatic load_inputs();
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 15; x++) i_board[2*(y*15+x) +: 2] = 2'(bx[x][y]);
    for (int k = 0; k < 10; k++) begin
      i_posX[5*k +: 5] = 5'(sx[k]);
      i_posY[5*k +: 5] = 5'(sy[k]);
    end
  endtask

  // poke > 0: pulse i_start with different list data at that cycle of the run.
  task automatic run_txn(input string tag, input int turn, input int win,
                         input int size_raw, input int poke);
    int ex, ey, en, lat, cyc;
    logic [3:0] held_x;
    model(turn, win, size_raw, ex, ey, en, lat);
    load_inputs();
    @(posedge i_clk); #1;
    i_start = 1'b1;
    i_turn  = 1'(turn);
    i_win   = 2'(win);
    i_size  = 5'(size_raw);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cyc = 1;
    while (!o_finish && cyc < 400) begin
      if (poke != 0 && cyc == poke) begin
        i_start = 1'b1;
        i_posX  = '0;
        i_posY  = '0;
        i_win   = 2'b01;
        i_size  = 5'd1;
      end
      @(posedge i_clk); #1;
      i_start = 1'b0;
      cyc++;
    end
    check({tag, ".latency"}, cyc, lat);
    check({tag, ".none"}, o_none, en);
    if (en == 0) begin
      check({tag, ".x"}, o_x, ex);
      check({tag, ".y"}, o_y, ey);
    end
    held_x = o_x;
    @(posedge i_clk); #1;
    check({tag, ".pulse_end"}, o_finish, 0);
    check({tag, ".hold_x"}, o_x, held_x);
  endtask

  initial begin
    int seen, dens;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_turn  = 1'b0;
    i_board = '0;
    i_posX  = '0;
    i_posY  = '0;
    i_size  = '0;
    i_win   = '0;
    clear_all();
    repeat (3) @(posedge i_clk);
    #1;
    check("reset.x", o_x, 0);
    check("reset.y", o_y, 0);
    check("reset.none", o_none, 0);
    check("reset.finish", o_finish, 0);
    i_rst_n = 1'b1;

    // Empty board, empty list.
    run_txn("empty_size0", 0, 0, 0, 0);

    // Forced slot 0.
    clear_all();
    sx[0] = 7; sy[0] = 7; sx[1] = 3; sy[1] = 3;
    run_txn("forced", 0, 1, 2, 0);

    // Black run through (7,7).
    clear_all();
    bx[5][7] = 1; bx[6][7] = 1; bx[8][7] = 1;
    sx[0] = 7; sy[0] = 7; sx[1] = 0; sy[1] = 0;
    run_txn("run_black", 0, 0, 2, 0);
    run_txn("run_white_turn", 1, 0, 2, 0);

    // Tie keeps slot 0; occupied slot 0 loses to slot 1.
    clear_all();
    sx[0] = 3; sy[0] = 3; sx[1] = 10; sy[1] = 10;
    run_txn("tie", 0, 0, 2, 0);
    bx[3][3] = 1;
    run_txn("slot0_occupied", 0, 0, 2, 0);

    // Off-board candidate skipped; oversized size clamps to 10.
    clear_all();
    sx[0] = 15; sy[0] = 3; sx[1] = 2; sy[1] = 20; sx[2] = 4; sy[2] = 4;
    bx[5][5] = 2; bx[6][6] = 2;
    run_txn("offboard", 0, 0, 3, 0);
    run_txn("size_clamp", 1, 0, 25, 0);

    // Ignored i_start during SCORE.
    run_txn("start_ignored", 0, 0, 3, 3);

    // Nearly full and full boards.
    clear_all();
    for (int x = 0; x < 15; x++)
      for (int y = 0; y < 15; y++) bx[x][y] = 1 + ((x + 2 * y) % 2);
    bx[14][14] = 0;
    run_txn("last_cell", 0, 0, 0, 0);
    bx[14][14] = 1;
    run_txn("full_board", 0, 0, 0, 0);
    sx[0] = 4; sy[0] = 9;
    run_txn("full_occupied_cand", 1, 0, 1, 0);

    // Reset in the middle of SCORE.
    clear_all();
    bx[1][1] = 1;
    sx[0] = 9; sy[0] = 9; sx[1] = 10; sy[1] = 10;
    run_txn("pre_reset", 0, 0, 2, 0);
    for (int k = 0; k < 6; k++) begin sx[k] = k + 2; sy[k] = 12 - k; end
    load_inputs();
    @(posedge i_clk); #1;
    i_start = 1'b1; i_size = 5'd6; i_win = 2'b00;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("midreset.x", o_x, 0);
    check("midreset.y", o_y, 0);
    check("midreset.none", o_none, 0);
    check("midreset.finish", o_finish, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    seen = 0;
    repeat (60) begin
      @(posedge i_clk); #1;
      if (o_finish) seen++;
    end
    check("midreset.no_finish", seen, 0);
    run_txn("after_reset", 0, 0, 6, 0);

    // Randomized boards and candidate lists.
    for (int r = 0; r < 40; r++) begin
      dens = $urandom_range(0, 100);
      for (int x = 0; x < 15; x++)
        for (int y = 0; y < 15; y++)
          bx[x][y] = ($urandom_range(0, 99) < dens) ? $urandom_range(1, 2) : 0;
      for (int k = 0; k < 10; k++) begin
        sx[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 31) : $urandom_range(0, 14);
        sy[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 31) : $urandom_range(0, 14);
      end
      run_txn($sformatf("rand%0d", r), $urandom_range(0, 1),
              ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
              $urandom_range(0, 13), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
